branch_cond_unit: RTL and testbench

BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

---
 rtl/branch_cond_unit.sv | 97 +++++++++
 tb/tb_branch_cond_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// Conditional-branch resolution unit: waits for in-flight flag writers, evaluates the
// condition code against zf/sf/of, and emits a one-cycle redirect for taken branches.
module branch_cond_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              flags_pending,
    input  logic              zf,
    input  logic              sf,
    input  logic              of,
    input  logic              pipe_flush,
    output logic              br_ready,
    output logic              stall,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [15:0]       taken_cnt,
    output logic [15:0]       resolved_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, EVAL} state_t;

    state_t              state;
    state_t              state_next;
    logic [2:0]          cond_q;
    logic [ADDR_W-1:0]   target_q;
    logic                accept;
    logic                resolve;
    logic                lt;
    logic                taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (pipe_flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (br_valid) state_next = flags_pending ? WAIT : EVAL;
                WAIT:    if (!flags_pending) state_next = EVAL;
                EVAL:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        br_ready = (state == IDLE);
        stall    = (state != IDLE);
        accept   = br_valid & br_ready & ~pipe_flush;
        // A flush in the EVAL cycle discards the branch: no redirect, no count.
        resolve  = (state == EVAL) & ~pipe_flush;
        lt       = sf ^ of;
        case (cond_q)
            3'b000:  taken = 1'b1;
            3'b001:  taken = zf;
            3'b010:  taken = ~zf;
            3'b011:  taken = lt;
            3'b100:  taken = ~lt;
            3'b101:  taken = ~zf & ~lt;
            3'b110:  taken = zf | lt;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_q         <= '0;
            target_q       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            taken_cnt      <= '0;
            resolved_cnt   <= '0;
        end else begin
            if (accept) begin
                cond_q   <= br_cond;
                target_q <= br_target;
            end
            redirect_valid <= resolve & taken;
            if (resolve & taken) begin
                redirect_pc <= target_q;
            end
            if (resolve) begin
                resolved_cnt <= resolved_cnt + 16'd1;
                if (taken) taken_cnt <= taken_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Self-checking bench for branch_cond_unit: condition table, directed corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_branch_cond_unit;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_target;
    logic        flags_pending;
    logic        zf;
    logic        sf;
    logic        of;
    logic        pipe_flush;
    logic        br_ready;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] taken_cnt;
    logic [15:0] resolved_cnt;

    int tests  = 0;
    int failed = 0;

    branch_cond_unit #(.ADDR_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .br_valid       (br_valid),
        .br_cond        (br_cond),
        .br_target      (br_target),
        .flags_pending  (flags_pending),
        .zf             (zf),
        .sf             (sf),
        .of             (of),
        .pipe_flush     (pipe_flush),
        .br_ready       (br_ready),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .taken_cnt      (taken_cnt),
        .resolved_cnt   (resolved_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one outstanding branch, remembered with whether its flags are final.
    bit          m_busy;
    bit          m_known;
    logic [2:0]  m_cond;
    logic [15:0] m_target;
    bit          m_rv;
    logic [15:0] m_pc;
    logic [15:0] m_taken;
    logic [15:0] m_res;

    function automatic bit cond_taken(input logic [2:0] c, input bit z, input bit s, input bit o);
        bit less;
        less = (s != o);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return less;
            3'd4:    return !less;
            3'd5:    return !z && !less;
            3'd6:    return z || less;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_known = 0; m_cond = '0; m_target = '0;
        m_rv = 0; m_pc = '0; m_taken = '0; m_res = '0;
    endtask

    task automatic model_edge();
        bit t;
        bit nrv;
        nrv = 0;
        if (m_busy && m_known && !pipe_flush) begin
            t = cond_taken(m_cond, zf, sf, of);
            m_res = m_res + 16'd1;
            if (t) begin
                m_taken = m_taken + 16'd1;
                m_pc = m_target;
            end
            nrv = t;
        end
        if (pipe_flush)            m_busy = 0;
        else if (m_busy && m_known) m_busy = 0;
        else if (m_busy)            m_known = !flags_pending;
        else if (br_valid) begin
            m_busy = 1; m_known = !flags_pending; m_cond = br_cond; m_target = br_target;
        end
        m_rv = nrv;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic compare_all(input string name);
        logic [50:0] got;
        logic [50:0] exp;
        got = {br_ready, stall, redirect_valid, redirect_pc, taken_cnt, resolved_cnt};
        exp = {!m_busy, m_busy, m_rv, m_pc, m_taken, m_res};
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: ready/stall/rv/pc/taken/res got %b/%b/%b/%h/%h/%h required %b/%b/%b/%h/%h/%h",
                     name, got[50], got[49], got[48], got[47:32], got[31:16], got[15:0],
                     exp[50], exp[49], exp[48], exp[47:32], exp[31:16], exp[15:0]);
        end
    endtask

    task automatic tick(input bit chk);
        model_edge();
        @(posedge clk);
        #1;
        if (chk) compare_all("cycle");
    endtask

    typedef struct {
        logic [2:0] cond;
        bit         z;
        bit         s;
        bit         o;
        bit         exp_taken;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [15:0] save_t;
        logic [15:0] save_r;
        int sc;
        int guard;

        vecs[0]  = '{3'd0, 0, 0, 0, 1};
        vecs[1]  = '{3'd1, 1, 0, 0, 1};
        vecs[2]  = '{3'd1, 0, 1, 0, 0};
        vecs[3]  = '{3'd2, 0, 0, 0, 1};
        vecs[4]  = '{3'd2, 1, 0, 0, 0};
        vecs[5]  = '{3'd3, 0, 1, 0, 1};
        vecs[6]  = '{3'd3, 0, 1, 1, 0};
        vecs[7]  = '{3'd4, 0, 0, 1, 0};
        vecs[8]  = '{3'd4, 0, 0, 0, 1};
        vecs[9]  = '{3'd5, 0, 1, 1, 1};
        vecs[10] = '{3'd5, 0, 1, 0, 0};
        vecs[11] = '{3'd5, 1, 0, 0, 0};
        vecs[12] = '{3'd6, 0, 0, 1, 1};
        vecs[13] = '{3'd6, 1, 0, 0, 1};
        vecs[14] = '{3'd6, 0, 0, 0, 0};
        vecs[15] = '{3'd7, 1, 1, 0, 0};

        rst = 1; br_valid = 0; br_cond = '0; br_target = '0; flags_pending = 0;
        zf = 0; sf = 0; of = 0; pipe_flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("reset_ready", 32'(br_ready), 32'd1);
        check("reset_stall", 32'(stall), 32'd0);
        compare_all("reset_state");

        // Simple taken branch, no pending flags
        br_valid = 1; br_cond = 3'b001; br_target = 16'h0040; zf = 1;
        tick(1);
        br_valid = 0;
        check("t1_stall", 32'(stall), 32'd1);
        tick(1);
        check("t1_rv", 32'(redirect_valid), 32'd1);
        check("t1_pc", 32'(redirect_pc), 32'h0040);
        check("t1_taken_cnt", 32'(taken_cnt), 32'd1);
        check("t1_resolved_cnt", 32'(resolved_cnt), 32'd1);
        check("t1_stall_done", 32'(stall), 32'd0);
        tick(1);
        check("t1_rv_pulse_end", 32'(redirect_valid), 32'd0);
        check("t1_pc_hold", 32'(redirect_pc), 32'h0040);

        // cond lt with sf==of: not taken
        br_valid = 1; br_cond = 3'b011; br_target = 16'h0077; sf = 1; of = 1; zf = 0;
        tick(1);
        br_valid = 0;
        tick(1);
        check("t2_rv", 32'(redirect_valid), 32'd0);
        check("t2_resolved_cnt", 32'(resolved_cnt), 32'd2);
        check("t2_taken_cnt", 32'(taken_cnt), 32'd1);

        // Pending flags held three edges; zf flips while waiting
        br_valid = 1; br_cond = 3'b001; br_target = 16'h0123; flags_pending = 1;
        zf = 0; sf = 0; of = 0;
        tick(1); br_valid = 0; sc = int'(stall);
        tick(1); sc += int'(stall); zf = 1;
        tick(1); sc += int'(stall); flags_pending = 0;
        tick(1); sc += int'(stall);
        tick(1); sc += int'(stall);
        check("t3_stall_cycles", 32'(sc), 32'd4);
        check("t3_rv", 32'(redirect_valid), 32'd1);
        check("t3_pc", 32'(redirect_pc), 32'h0123);

        // Flush during WAIT
        save_t = m_taken; save_r = m_res;
        br_valid = 1; br_cond = 3'b000; br_target = 16'h0bad; flags_pending = 1;
        tick(1); br_valid = 0; pipe_flush = 1;
        tick(1); pipe_flush = 0; flags_pending = 0;
        check("t4_ready", 32'(br_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("t4_no_rv", 32'(redirect_valid), 32'd0);
        end
        check("t4_res_unchanged", 32'(resolved_cnt), 32'(save_r));
        check("t4_taken_unchanged", 32'(taken_cnt), 32'(save_t));

        // Flush during EVAL, then flush coinciding with br_valid in IDLE
        br_valid = 1; br_cond = 3'b000; br_target = 16'h0bee;
        tick(1); br_valid = 0; pipe_flush = 1;
        tick(1); pipe_flush = 0;
        check("t5_no_rv", 32'(redirect_valid), 32'd0);
        check("t5_res_unchanged", 32'(resolved_cnt), 32'(save_r));
        br_valid = 1; pipe_flush = 1;
        tick(1); br_valid = 0; pipe_flush = 0;
        check("t6_not_accepted", 32'(br_ready), 32'd1);

        // Condition table, back-to-back (next branch offered during redirect cycle)
        foreach (vecs[i]) begin
            br_valid = 1; br_cond = vecs[i].cond; br_target = 16'h1000 + 16'(i);
            zf = vecs[i].z; sf = vecs[i].s; of = vecs[i].o; flags_pending = 0;
            tick(1);
            br_valid = 0;
            tick(1);
            check($sformatf("cond%0d_vec%0d_rv", vecs[i].cond, i), 32'(redirect_valid), 32'(vecs[i].exp_taken));
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            br_valid      = ($urandom_range(0, 1) == 1);
            br_cond       = 3'($urandom_range(0, 7));
            br_target     = 16'($urandom);
            flags_pending = ($urandom_range(0, 9) < 3);
            zf            = 1'($urandom);
            sf            = 1'($urandom);
            of            = 1'($urandom);
            pipe_flush    = ($urandom_range(0, 11) == 0);
            tick(1);
        end
        pipe_flush = 0; flags_pending = 0; br_valid = 0;
        tick(1); tick(1);

        // Fill resolved_cnt to 0xFFFF, then wrap
        br_valid = 1; br_cond = 3'b111; guard = 0;
        while (m_res != 16'hFFFF && guard < 140000) begin
            tick(0);
            guard++;
        end
        br_valid = 0;
        check("fill_within_budget", 32'(guard < 140000), 32'd1);
        check("fill_res_ffff", 32'(resolved_cnt), 32'hFFFF);
        compare_all("fill_state");
        br_valid = 1;
        tick(1); br_valid = 0;
        tick(1);
        check("wrap_res_zero", 32'(resolved_cnt), 32'h0000);

        // Async reset mid-EVAL
        br_valid = 1; br_cond = 3'b000; br_target = 16'h4444;
        tick(1); br_valid = 0;
        check("t8_in_eval", 32'(stall), 32'd1);
        #3 rst = 1;
        #1;
        model_reset();
        check("t8_stall_zero", 32'(stall), 32'd0);
        check("t8_rv_zero", 32'(redirect_valid), 32'd0);
        check("t8_pc_zero", 32'(redirect_pc), 32'd0);
        check("t8_taken_zero", 32'(taken_cnt), 32'd0);
        check("t8_res_zero", 32'(resolved_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 0;
        check("t8_ready_after_rst", 32'(br_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("t8_no_rv", 32'(redirect_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
